// File: rtl/cpu1_sw_rst_ctrl.sv
// CPU1 software-reset push-button sequencer: synchronise, debounce, capture presses,
// and drive a timed reset-request pulse, with an Avalon-MM register slave for control.
module cpu1_sw_rst_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int RST_HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_port,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        rst_req
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    logic              sync_meta_r;
    logic              sync_r;
    logic              db_r;
    logic              db_q_r;
    logic [CNT_W-1:0]  db_cnt_r;
    logic              press_r;
    logic              auto_en_r;
    logic              irq_en_r;
    logic              sw_trig_r;
    logic              edge_r;
    logic [7:0]        press_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              rst_req_r;
    logic              irq_r;
    logic [31:0]       readdata_r;
    state_t            state_r;
    state_t            state_nxt_s;
    logic              wr_s;
    logic              trigger_s;
    logic [31:0]       rd_mux_s;
    logic              unused_wr_s;

    assign wr_s        = chipselect & ~write_n;
    assign trigger_s   = (press_r & auto_en_r) | sw_trig_r;
    assign unused_wr_s = ^writedata[31:3];

    // Two-flop synchroniser for the raw switch.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
        end else begin
            sync_meta_r <= in_port;
            sync_r      <= sync_meta_r;
        end
    end

    // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_r     <= 1'b0;
            db_cnt_r <= {CNT_W{1'b0}};
        end else if (sync_r != db_r) begin
            if (db_cnt_r == DB_LAST) begin
                db_r     <= sync_r;
                db_cnt_r <= {CNT_W{1'b0}};
            end else begin
                db_cnt_r <= db_cnt_r + CNT_W'(1);
            end
        end else begin
            db_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Registered rising-edge detect on the debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_q_r  <= 1'b0;
            press_r <= 1'b0;
        end else begin
            db_q_r  <= db_r;
            press_r <= db_r & ~db_q_r;
        end
    end

    // CTRL register; sw_trig is a one-cycle strobe that never holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            auto_en_r <= 1'b1;
            irq_en_r  <= 1'b0;
            sw_trig_r <= 1'b0;
        end else if (wr_s && (address == 2'd1)) begin
            auto_en_r <= writedata[0];
            irq_en_r  <= writedata[1];
            sw_trig_r <= writedata[2];
        end else begin
            sw_trig_r <= 1'b0;
        end
    end

    // EDGE capture (a press beats a simultaneous clear), press counter and interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_r      <= 1'b0;
            press_cnt_r <= 8'd0;
            irq_r       <= 1'b0;
        end else begin
            if (press_r) begin
                edge_r      <= 1'b1;
                press_cnt_r <= press_cnt_r + 8'd1;
            end else if (wr_s && (address == 2'd2) && writedata[0]) begin
                edge_r <= 1'b0;
            end
            irq_r <= irq_en_r & edge_r;
        end
    end

    // Sequencer state, pulse-length counter and registered reset request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= {HOLD_W{1'b0}};
            rst_req_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rst_req_r <= (state_nxt_s == ST_ASSERT);
            if (state_r == ST_ASSERT) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_cnt_r <= {HOLD_W{1'b0}};
            end
        end
    end

    // Next-state logic; triggers outside IDLE do not restart the pulse.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_nxt_s = ST_ASSERT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s = ST_WAIT_REL;
                end else begin
                    state_nxt_s = ST_ASSERT;
                end
            end
            ST_WAIT_REL: begin
                if (!db_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_REL;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Read mux for the registered readdata path.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (address)
            2'd0:    rd_mux_s = {30'd0, sync_r, db_r};
            2'd1:    rd_mux_s = {29'd0, 1'b0, irq_en_r, auto_en_r};
            2'd2:    rd_mux_s = {31'd0, edge_r};
            2'd3:    rd_mux_s = {16'd0, press_cnt_r, 6'd0, state_r};
            default: rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Readdata refreshes every cycle; there is no read strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_r <= 32'h0000_0000;
        end else begin
            readdata_r <= rd_mux_s;
        end
    end

    assign readdata = readdata_r;
    assign irq      = irq_r;
    assign rst_req  = rst_req_r;

endmodule

// File: tb/tb_cpu1_sw_rst_ctrl.sv
// Scoreboard bench for cpu1_sw_rst_ctrl: reads and reset pulses are predicted into
// queues by the stimulus and popped by independent monitors.
module tb_cpu1_sw_rst_ctrl;

    logic        clk;
    logic        reset;
    logic        in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        rst_req;

    int total = 0;
    int bad   = 0;

    logic        rd_issue = 1'b0;
    logic        rd_v     = 1'b0;
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    int          pw_q[$];
    int          pw = 0;

    cpu1_sw_rst_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16),
        .RST_HOLD_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_port(in_port),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq),
        .rst_req(rst_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Read monitor: the read issued before a sampling edge is checked at the following negedge.
    always @(posedge clk) rd_v <= rd_issue;

    always @(negedge clk) begin
        if (rd_v) begin
            if (rd_exp_q.size() == 0) begin
                check("rd_unexpected", readdata, 32'hFFFF_FFFF);
            end else begin
                check(rd_name_q.pop_front(), readdata, rd_exp_q.pop_front());
            end
        end
    end

    // Pulse monitor: measure every rst_req pulse width and compare with the predicted one.
    always @(negedge clk) begin
        if (rst_req === 1'b1) begin
            pw = pw + 1;
        end else if (pw != 0) begin
            if (pw_q.size() == 0) begin
                check("rst_req_unexpected_pulse", 32'(pw), 32'd0);
            end else begin
                check("rst_req_width", 32'(pw), 32'(pw_q.pop_front()));
            end
            pw = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
        address  = a;
        rd_issue = 1'b1;
        rd_exp_q.push_back(e);
        rd_name_q.push_back(n);
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_port    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;

        // Reset values
        tick(2);
        reset = 1'b0;
        rd(2'd0, 32'h0, "rst_data");
        rd(2'd1, 32'h1, "rst_ctrl");
        rd(2'd2, 32'h0, "rst_edge");
        rd(2'd3, 32'h0, "rst_status");
        check("rst_rst_req", {31'd0, rst_req}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Glitch rejection: 3 cycles is one short of the debounce window
        in_port = 1'b1;
        tick(3);
        in_port = 1'b0;
        tick(8);
        rd(2'd0, 32'h0, "glitch_data");
        rd(2'd2, 32'h0, "glitch_edge");
        rd(2'd3, 32'h0, "glitch_status");

        // Debounced press with automatic reset pulse
        pw_q.push_back(3);
        in_port = 1'b1;
        tick(14);
        rd(2'd3, 32'h0000_0102, "press_status_held");
        rd(2'd2, 32'h1, "press_edge");
        rd(2'd0, 32'h3, "press_data_held");
        tick(3);
        in_port = 1'b0;
        tick(10);
        rd(2'd3, 32'h0000_0100, "press_status_released");
        rd(2'd0, 32'h0, "press_data_released");

        // Software trigger, then irq set by a press and cleared by W1C
        wr(2'd2, 32'h1);
        pw_q.push_back(3);
        wr(2'd1, 32'h6);
        check("sw_irq_quiet", {31'd0, irq}, 32'd0);
        tick(6);
        rd(2'd3, 32'h0000_0100, "sw_status_idle");
        rd(2'd1, 32'h2, "sw_ctrl_readback");
        in_port = 1'b1;
        tick(12);
        check("irq_after_press", {31'd0, irq}, 32'd1);
        in_port = 1'b0;
        tick(10);
        rd(2'd2, 32'h1, "irq_edge_set");
        wr(2'd2, 32'h1);
        check("irq_before_clear_lag", {31'd0, irq}, 32'd1);
        tick(1);
        check("irq_after_clear", {31'd0, irq}, 32'd0);

        // Triggers during ASSERT are ignored; the counter still advances
        wr(2'd1, 32'h1);
        pw_q.push_back(3);
        in_port = 1'b1;
        tick(4);
        wr(2'd1, 32'h5);
        wr(2'd1, 32'h5);
        tick(10);
        in_port = 1'b0;
        tick(12);
        rd(2'd3, 32'h0000_0300, "ignored_status");
        rd(2'd2, 32'h1, "ignored_edge");

        // Counter wrap with auto reset disabled
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        wr(2'd1, 32'h0);
        for (int i = 0; i < 255; i++) begin
            in_port = 1'b1;
            tick(7);
            in_port = 1'b0;
            tick(7);
        end
        rd(2'd3, 32'h0000_FF00, "wrap_cnt_255");
        in_port = 1'b1;
        tick(7);
        in_port = 1'b0;
        tick(7);
        rd(2'd3, 32'h0000_0000, "wrap_cnt_0");

        // Press and W1C in the same cycle: set wins
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h0, "collide_pre_clear");
        in_port = 1'b1;
        tick(7);
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h1, "collide_edge");
        in_port = 1'b0;
        tick(10);
        rd(2'd3, 32'h0000_0100, "collide_cnt");

        // Reset in the middle of ASSERT cuts the pulse
        pw_q.push_back(1);
        wr(2'd1, 32'h4);
        tick(1);
        check("midrst_rst_req_high", {31'd0, rst_req}, 32'd1);
        reset = 1'b1;
        tick(1);
        check("midrst_rst_req_low", {31'd0, rst_req}, 32'd0);
        reset = 1'b0;
        rd(2'd3, 32'h0, "midrst_status");
        rd(2'd1, 32'h1, "midrst_ctrl");
        tick(4);

        check("pulses_outstanding", 32'(pw_q.size()), 32'd0);
        check("reads_outstanding", 32'(rd_exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
